w_slave: RTL and testbench

Wishbone responder for the lab3 memory subsystem: the far end of `w_master`. Accepts single classic-cycle read/write transfers on the 26-bit address / 32-bit data bus, applies a programmable number of wait states, and services them from an internal word-addressed RAM. `ack_o` and `tagn_o` complete the handshake that the master initiates.

---
 rtl/w_bus_pkg.sv | 22 ++
 rtl/w_slave_ram.sv | 29 ++
 rtl/w_slave.sv | 152 +++++++++++++++
 tb/tb_w_slave.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_bus_pkg.sv
// rtl/w_bus_pkg.sv - shared Wishbone bus widths, state encoding and constants
package w_bus_pkg;

    localparam int ADR_W = 26;
    localparam int DAT_W = 32;

    localparam logic [DAT_W-1:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } w_state_e;

    // Source currently driving the read-data output
    typedef enum logic [1:0] {
        RD_ZERO     = 2'd0,
        RD_RAM      = 2'd1,
        RD_UNMAPPED = 2'd2
    } w_rd_src_e;

endpackage

// File: rtl/w_slave_ram.sv
// rtl/w_slave_ram.sv - single-port synchronous RAM with registered read, no reset
module w_slave_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write on we_i; read data captured only on re_i so it holds otherwise
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/w_slave.sv
// rtl/w_slave.sv - Wishbone classic-cycle responder with wait states and internal RAM
module w_slave
    import w_bus_pkg::*;
#(
    parameter int               AW_WORDS    = 10,
    parameter int               WAIT_STATES = 1,
    parameter logic [ADR_W-1:0] BASE        = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [DAT_W-1:0] dat_i,
    input  logic             we_i,
    input  logic             stb_i,
    input  logic             cyc_i,
    input  logic             tagn_i,
    output logic [DAT_W-1:0] dat_o,
    output logic             ack_o,
    output logic             tagn_o
);

    localparam int               HI_W    = ADR_W - AW_WORDS - 2;
    localparam logic [HI_W-1:0]  BASE_HI = BASE[HI_W-1:0];
    localparam logic [3:0]       WS      = 4'(WAIT_STATES);

    w_state_e              state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW_WORDS-1:0]   word_q;
    logic [DAT_W-1:0]      wdat_q;
    logic                  we_q, sel_q, tag_q;
    w_rd_src_e             rd_src_q;

    logic                  req, sel_in, take_req, do_access;
    logic                  acc_sel, acc_we;
    logic [AW_WORDS-1:0]   acc_word;
    logic [DAT_W-1:0]      acc_dat;
    logic                  ram_we, ram_re;
    logic [DAT_W-1:0]      ram_rdata;
    logic                  unused_adr_lsb;

    assign req            = cyc_i & stb_i;
    assign sel_in         = (adr_i[ADR_W-1:AW_WORDS+2] == BASE_HI);
    assign unused_adr_lsb = ^adr_i[1:0];

    // Next-state logic: request capture, wait countdown with abort, single ACK cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        take_req  = 1'b0;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    take_req = 1'b1;
                    cnt_d    = WS;
                    if (WS == 4'd0) begin
                        state_d   = ACK;
                        do_access = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d   = ACK;
                    do_access = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With zero wait states the access happens on the capture edge, so use live inputs
    always_comb begin
        acc_sel  = sel_q;
        acc_we   = we_q;
        acc_word = word_q;
        acc_dat  = wdat_q;
        if (state_q == IDLE) begin
            acc_sel  = sel_in;
            acc_we   = we_i;
            acc_word = adr_i[AW_WORDS+1:2];
            acc_dat  = dat_i;
        end
    end

    // RAM strobes are gated by reset so a pending write can never land while held in reset
    assign ram_we = do_access & acc_sel & acc_we & ~rst_i;
    assign ram_re = do_access & acc_sel & ~acc_we & ~rst_i;

    // State, counter, request latches and read-data source selection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            word_q   <= '0;
            wdat_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            tag_q    <= 1'b0;
            rd_src_q <= RD_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take_req) begin
                word_q <= adr_i[AW_WORDS+1:2];
                wdat_q <= dat_i;
                we_q   <= we_i;
                sel_q  <= sel_in;
                tag_q  <= tagn_i;
            end
            if (do_access && !acc_we) begin
                rd_src_q <= acc_sel ? RD_RAM : RD_UNMAPPED;
            end
        end
    end

    w_slave_ram #(
        .AW (AW_WORDS),
        .DW (DAT_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (acc_word),
        .wdata_i (acc_dat),
        .rdata_o (ram_rdata)
    );

    assign ack_o  = (state_q == ACK);
    assign tagn_o = tag_q;

    // Read data is chosen from registered sources only; reset forces zero
    always_comb begin
        dat_o = '0;
        case (rd_src_q)
            RD_RAM:      dat_o = ram_rdata;
            RD_UNMAPPED: dat_o = UNMAPPED_DATA;
            default:     dat_o = '0;
        endcase
    end

endmodule

// File: tb/tb_w_slave.sv
// tb/tb_w_slave.sv - directed self-checking bench for w_slave
module tb_w_slave;

    logic        clk;
    logic        rst;
    logic [25:0] adr;
    logic [31:0] dat_i;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        tagn;

    logic        ack_v [4];
    logic [31:0] dat_v [4];
    logic        tag_v [4];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    w_slave #(.AW_WORDS(10), .WAIT_STATES(0), .BASE(26'h0)) dut0 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_i), .we_i(we), .stb_i(stb),
        .cyc_i(cyc), .tagn_i(tagn), .dat_o(dat_v[0]), .ack_o(ack_v[0]), .tagn_o(tag_v[0]));
    w_slave #(.AW_WORDS(10), .WAIT_STATES(1), .BASE(26'h0)) dut1 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_i), .we_i(we), .stb_i(stb),
        .cyc_i(cyc), .tagn_i(tagn), .dat_o(dat_v[1]), .ack_o(ack_v[1]), .tagn_o(tag_v[1]));
    w_slave #(.AW_WORDS(10), .WAIT_STATES(2), .BASE(26'h0)) dut2 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_i), .we_i(we), .stb_i(stb),
        .cyc_i(cyc), .tagn_i(tagn), .dat_o(dat_v[2]), .ack_o(ack_v[2]), .tagn_o(tag_v[2]));
    w_slave #(.AW_WORDS(10), .WAIT_STATES(3), .BASE(26'h0)) dut3 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_i), .we_i(we), .stb_i(stb),
        .cyc_i(cyc), .tagn_i(tagn), .dat_o(dat_v[3]), .ack_o(ack_v[3]), .tagn_o(tag_v[3]));

    // Drive one transfer, wait (bounded) for ack from instance ws, then drop the strobe
    task automatic xfer(input int ws, input logic [25:0] a, input logic [31:0] d,
                        input logic w, input logic t, output logic ok, output int lat,
                        output logic [31:0] rd, output logic tg, output logic ack_next);
        @(negedge clk);
        adr = a; dat_i = d; we = w; tagn = t; cyc = 1'b1; stb = 1'b1;
        ok = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (ack_v[ws]) begin
                ok = 1'b1;
                lat = i;
            end
        end
        rd = dat_v[ws];
        tg = tag_v[ws];
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        #1;
        ack_next = ack_v[ws];
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; tagn = 1'b0; adr = '0; dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_v[i] !== 1'b0) begin
                errors++; $display("FAIL reset_ack[%0d] got=%b exp=0", i, ack_v[i]);
            end
            checks++;
            if (dat_v[i] !== 32'h0) begin
                errors++; $display("FAIL reset_dat[%0d] got=%h exp=0", i, dat_v[i]);
            end
            checks++;
            if (tag_v[i] !== 1'b0) begin
                errors++; $display("FAIL reset_tag[%0d] got=%b exp=0", i, tag_v[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ws1_rw();
        logic ok, tg, an; int lat; logic [31:0] rd;
        xfer(1, 26'h000_0010, 32'h1234_5678, 1'b1, 1'b0, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 2) begin
            errors++; $display("FAIL ws1_write_latency got=%0d ok=%b exp=2", lat, ok);
        end
        checks++;
        if (an !== 1'b0) begin
            errors++; $display("FAIL ws1_ack_pulse got=%b exp=0", an);
        end
        xfer(1, 26'h000_0010, 32'h0, 1'b0, 1'b1, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 2) begin
            errors++; $display("FAIL ws1_read_latency got=%0d ok=%b exp=2", lat, ok);
        end
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL ws1_read_data got=%h exp=12345678", rd);
        end
        checks++;
        if (tg !== 1'b1) begin
            errors++; $display("FAIL ws1_read_tag got=%b exp=1", tg);
        end
    endtask

    task automatic test_back_to_back();
        logic ok, tg, an; int lat; logic [31:0] rd;
        xfer(0, 26'h000_0010, 32'h4444_0004, 1'b1, 1'b0, ok, lat, rd, tg, an);
        xfer(0, 26'h000_0014, 32'h5555_0005, 1'b1, 1'b0, ok, lat, rd, tg, an);
        xfer(0, 26'h000_0010, 32'h0, 1'b0, 1'b0, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 1) begin
            errors++; $display("FAIL b2b_lat_w4 got=%0d ok=%b exp=1", lat, ok);
        end
        checks++;
        if (rd !== 32'h4444_0004) begin
            errors++; $display("FAIL b2b_data_w4 got=%h exp=44440004", rd);
        end
        checks++;
        if (an !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_gap got=%b exp=0", an);
        end
        xfer(0, 26'h000_0014, 32'h0, 1'b0, 1'b1, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 1) begin
            errors++; $display("FAIL b2b_lat_w5 got=%0d ok=%b exp=1", lat, ok);
        end
        checks++;
        if (rd !== 32'h5555_0005) begin
            errors++; $display("FAIL b2b_data_w5 got=%h exp=55550005", rd);
        end
    endtask

    task automatic test_unmapped();
        logic ok, tg, an; int lat; logic [31:0] rd;
        xfer(1, 26'h000_0000, 32'h0000_C0DE, 1'b1, 1'b0, ok, lat, rd, tg, an);
        xfer(1, 26'h100_0000, 32'h0, 1'b0, 1'b0, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 2) begin
            errors++; $display("FAIL unmapped_read_ack got=%0d ok=%b exp=2", lat, ok);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL unmapped_read_data got=%h exp=deadbeef", rd);
        end
        xfer(1, 26'h100_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 2) begin
            errors++; $display("FAIL unmapped_write_ack got=%0d ok=%b exp=2", lat, ok);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_holds_dat got=%h exp=deadbeef", rd);
        end
        xfer(1, 26'h000_0000, 32'h0, 1'b0, 1'b0, ok, lat, rd, tg, an);
        checks++;
        if (rd !== 32'h0000_C0DE) begin
            errors++; $display("FAIL word0_unchanged got=%h exp=0000c0de", rd);
        end
    endtask

    task automatic test_abort();
        logic ok, tg, an, seen; int lat; logic [31:0] rd;
        xfer(3, 26'h000_0020, 32'h1111_1111, 1'b1, 1'b0, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 4) begin
            errors++; $display("FAIL ws3_write_latency got=%0d ok=%b exp=4", lat, ok);
        end
        @(negedge clk);
        adr = 26'h000_0020; dat_i = 32'h2222_2222; we = 1'b1; tagn = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack_v[3]) seen = 1'b1;
        end
        stb = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_ack got=%b exp=0", seen);
        end
        xfer(3, 26'h000_0020, 32'h0, 1'b0, 1'b0, ok, lat, rd, tg, an);
        checks++;
        if (rd !== 32'h1111_1111) begin
            errors++; $display("FAIL abort_not_written got=%h exp=11111111", rd);
        end
    endtask

    task automatic test_reset_midop();
        logic ok, tg, an; int lat; logic [31:0] rd;
        xfer(2, 26'h000_0030, 32'h0000_00AA, 1'b1, 1'b0, ok, lat, rd, tg, an);
        xfer(2, 26'h000_0030, 32'h0, 1'b0, 1'b1, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 3 || rd !== 32'h0000_00AA) begin
            errors++; $display("FAIL ws2_read got=%h lat=%0d exp=000000aa lat=3", rd, lat);
        end
        @(negedge clk);
        adr = 26'h000_0030; dat_i = 32'h5555_5555; we = 1'b1; tagn = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (dat_v[2] !== 32'h0000_00AA || tag_v[2] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_hold dat=%h tag=%b exp=000000aa tag=1", dat_v[2], tag_v[2]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ack_v[2] !== 1'b0) begin
            errors++; $display("FAIL async_rst_ack got=%b exp=0", ack_v[2]);
        end
        checks++;
        if (dat_v[2] !== 32'h0) begin
            errors++; $display("FAIL async_rst_dat got=%h exp=0", dat_v[2]);
        end
        checks++;
        if (tag_v[2] !== 1'b0) begin
            errors++; $display("FAIL async_rst_tag got=%b exp=0", tag_v[2]);
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer(2, 26'h000_0030, 32'h0, 1'b0, 1'b0, ok, lat, rd, tg, an);
        checks++;
        if (!ok || lat != 3) begin
            errors++; $display("FAIL post_reset_latency got=%0d ok=%b exp=3", lat, ok);
        end
        checks++;
        if (rd !== 32'h0000_00AA) begin
            errors++; $display("FAIL rst_write_discarded got=%h exp=000000aa", rd);
        end
    endtask

    task automatic test_tag();
        logic ok, tg, an, exp_t; int lat; logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            exp_t = (i % 2 == 0);
            xfer(1, 26'(26'h40 + 4 * i), 32'(i), 1'b1, exp_t, ok, lat, rd, tg, an);
            checks++;
            if (!ok || tg !== exp_t) begin
                errors++; $display("FAIL tag_echo[%0d] got=%b ok=%b exp=%b", i, tg, ok, exp_t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ws1_rw();
        test_back_to_back();
        test_unmapped();
        test_abort();
        test_reset_midop();
        test_tag();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
